seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus and one BCD-to-segment decoder. It holds a double-buffered BCD digit vector and cycles an active-low anode enable across the digits. A guard blank between digits prevents ghosting, and new values are swapped in only at frame boundaries so the display never tears. It sits between the counter/datapath that produces BCD values and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is rightmost/least significant
DWELL_CYCLES, 50000, clk cycles each digit is lit (>=1)
GUARD_CYCLES, 500, clk cycles all anodes are off before each digit (0 = no guard)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = scan; 0 = display dark, scan held
load  input  1  strobe: capture digits_in this edge
digits_in  input  4*NUM_DIGITS  BCD digits, digit i at [4i+3:4i]
seg  output  7  active-low segments, bit6..0 = g..a
an  output  NUM_DIGITS  active-low anode enables, bit i = digit i
pending  output  1  staged value waiting for frame boundary
frame_tick  output  1  one-cycle pulse on last lit cycle of digit NUM_DIGITS-1

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high; its assertion acts immediately, mid-frame included.
- Reset values: seg=7'h7F, an=all ones, pending=0, frame_tick=0. Shadow and staged registers = all 4'hF (blank). idx=0, cycle counter=0, state=GUARD.
- FSM states:
  - GUARD: lasts GUARD_CYCLES cycles. an=all ones, seg=7'h7F. Skipped entirely when GUARD_CYCLES=0.
  - DWELL: lasts DWELL_CYCLES cycles. an[idx]=0, all other anodes 1. seg=decode(shadow[idx]).
  - At the end of DWELL: idx <= (idx+1) mod NUM_DIGITS, then back to GUARD.
- seg, an and frame_tick are registered: each reflects the state one cycle after the state/counter change.
- Frame period is exactly NUM_DIGITS*(GUARD_CYCLES+DWELL_CYCLES) cycles.
- Decode table (active-low g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10..15 = 1111111 (blank); the anode still scans.
- Counter width is $clog2(max(DWELL_CYCLES,GUARD_CYCLES)+1). idx width is $clog2(NUM_DIGITS); it wraps explicitly, never by overflow.
- load handling:
  - load=1 at an edge: staged <= digits_in, pending <= 1.
  - Frame boundary (the frame_tick cycle) with pending=1: shadow <= staged, pending <= 0.
  - load in the same cycle as the frame boundary: shadow <= digits_in directly, pending <= 0. The newest value wins.
  - Back-to-back loads: the last one before the boundary wins; earlier ones are silently dropped.
- enable=0:
  - Next edge: an=all ones, seg=7'h7F, frame_tick=0.
  - FSM forced to GUARD with idx=0 and counter=0.
  - load writes shadow directly; pending is cleared to 0.
- enable rising: scanning restarts at GUARD, idx 0, showing the current shadow.

Optional Feature:
SEG_LZ_BLANK_EN
- Defined: leading-zero blanking. Any digit i above the most significant nonzero shadow digit shows seg=7'h7F while its anode still scans. Digit 0 is never blanked, so an all-zero value shows "0". The blank mask is computed from shadow and updates with it.
- Undefined: every digit 0..9 is displayed as-is.

Decomposition:
- Shared package seg_pkg:
  - segment constants SEG_BLANK=7'h7F and the 0..9 codes
  - scan state enum {S_GUARD, S_DWELL}
  - BCD_W=4
- Sub-module: the team's existing combinational BCD-to-segment module `decoder` (m[3:0] -> seg[6:0]). One instance, fed by the shadow digit mux; seg is registered after it.

Test Plan:
(NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=1)
1. Reset held, then released -> seg=7'h7F, an=4'hF during reset. After release, an shows the repeating pattern 1111,1110x4,1111,1101x4,... with seg=7'h7F throughout (blank shadow). frame_tick pulses every 20 cycles.
2. load 16'h1234 mid-frame -> pending=1 until the frame_tick cycle, then 0. In the next frame: an=1110 gives seg=0011001 (4); an=0111 gives seg=1111001 (1).
3. load 16'h1111 then 16'h5678 before the boundary -> only 5678 is shown. load 16'h9999 in the frame_tick cycle -> next frame shows 9 on all digits (seg=0010000), pending=0.
4. load 16'hABCD -> all lit slots show seg=7'h7F while an still scans. Assert rst during DWELL -> seg=7'h7F and an=4'hF before the next edge.
5. enable=0 -> an=4'hF on the next edge. load 16'h0042 while disabled -> pending stays 0. enable=1 -> after 1 guard cycle, an=1110 with seg=0100100 (2).
6. load 16'h0050:
   - SEG_LZ_BLANK_EN defined -> digits 3 and 2 show 7'h7F, digit 1 shows 0010010 (5), digit 0 shows 1000000 (0).
   - Macro undefined -> digits 3 and 2 show 1000000.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: BCD digit width, active-low g..a segment codes, scan state enum.
package seg_pkg;

    localparam int BCD_W = 4;

    // Active-low segment patterns, bit6..0 = g..a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic {
        S_GUARD,
        S_DWELL
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle between the BCD producer and the scan controller / display pins.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe.
// Ports: master drives enable/load/digits_in and observes seg/an/pending/frame_tick;
//        slave is the controller side.
interface seg_scan_ctrl_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    logic                          enable;
    logic                          load;
    logic [BCD_W*NUM_DIGITS-1:0]   digits_in;
    logic [6:0]                    seg;
    logic [NUM_DIGITS-1:0]         an;
    logic                          pending;
    logic                          frame_tick;

    modport master (
        output enable, load, digits_in,
        input  seg, an, pending, frame_tick
    );

    modport slave (
        input  enable, load, digits_in,
        output seg, an, pending, frame_tick
    );

endinterface

// File: rtl/decoder.sv
// BCD to active-low 7-segment decoder; codes 10..15 decode to blank.
// Latency: combinational.
// Backpressure: none.
// Ports: m = BCD digit in, seg = active-low g..a out.
module decoder
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] m,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (m)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with guard blanking and frame-synchronous update.
// Latency: seg/an/frame_tick registered, one cycle behind the scan state; staged loads land at frame end.
// Backpressure: none; later loads before the frame boundary overwrite earlier staged ones.
// Ports: clk, rst (async, active-high), bus (slave modport: enable, load, digits_in, seg, an,
//        pending, frame_tick). Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_ctrl_if.slave    bus
);

    localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DIG_W   = BCD_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // With no guard the scan goes straight from one dwell into the next.
    localparam scan_state_t START_STATE = (GUARD_CYCLES == 0) ? S_DWELL : S_GUARD;

    scan_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              frame_end;

    logic [DIG_W-1:0]  shadow, shadow_nxt;
    logic [DIG_W-1:0]  staged, staged_nxt;
    logic              pending_q, pending_nxt;

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_tick_q;

    logic [BCD_W-1:0]      cur_digit;
    logic                  cur_blank;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] lz_mask;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START_STATE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        frame_end = 1'b0;
        if (!bus.enable) begin
            state_nxt = START_STATE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state_nxt = S_DWELL;
                        cnt_nxt   = '0;
                    end
                end
                S_DWELL: begin
                    if (cnt == DWELL_LAST) begin
                        state_nxt = START_STATE;
                        cnt_nxt   = '0;
                        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        frame_end = (idx == IDX_LAST);
                    end
                end
                default: begin
                    state_nxt = START_STATE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ---------------- double buffer ----------------
    // The boundary is the cycle in which frame_tick is high. While disabled every
    // cycle is a boundary, so loads go straight to the shadow register.
    always_comb begin
        shadow_nxt  = shadow;
        staged_nxt  = staged;
        pending_nxt = pending_q;
        if (bus.load) begin
            staged_nxt = bus.digits_in;
        end
        if (!bus.enable || frame_tick_q) begin
            if (bus.load) begin
                shadow_nxt = bus.digits_in;
            end else if (pending_q) begin
                shadow_nxt = staged;
            end
            pending_nxt = 1'b0;
        end else if (bus.load) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= {NUM_DIGITS{4'hF}};
            staged    <= {NUM_DIGITS{4'hF}};
            pending_q <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            staged    <= staged_nxt;
            pending_q <= pending_nxt;
        end
    end

    // ---------------- digit select / decode ----------------
    // Decode from the next shadow value so a swap at the boundary edge is
    // already visible in the segment register it loads alongside.
`ifdef SEG_LZ_BLANK_EN
    always_comb begin : lz_calc
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_nxt[i*BCD_W +: BCD_W] == 4'd0);
            lz_mask[i] = zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = shadow_nxt[i*BCD_W +: BCD_W];
                cur_blank = lz_mask[i];
            end
        end
    end

    decoder u_decoder (
        .m   (cur_digit),
        .seg (dec_seg)
    );

    // ---------------- registered pin drivers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else if (!bus.enable) begin
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_end;
            if (state == S_DWELL) begin
                an_q  <= ~(NUM_DIGITS'(1) << idx);
                seg_q <= cur_blank ? SEG_BLANK : dec_seg;
            end else begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=1.
// Latency: frame is 20 cycles; samples taken on the falling edge.
// Backpressure: n/a.
module tb_seg_scan_ctrl;

    localparam logic [6:0] SB = 7'h7F;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.load = 1'b0;
        end
    endtask

    // Bounded wait for a falling edge where frame_tick is high.
    task automatic wait_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            seen = bus.frame_tick;
        end
        if (!seen) chk({tag, ":tick_timeout"}, 32'd0, 32'd1);
    endtask

    // Checks one full 20-cycle frame starting at the guard of digit 0.
    task automatic show_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        logic [6:0] d [4];
        logic [3:0] ea;
        logic [6:0] es;
        int dig, w;
        d[0] = s0; d[1] = s1; d[2] = s2; d[3] = s3;
        for (int p = 0; p < 20; p++) begin
            @(negedge clk);
            bus.load = 1'b0;
            dig = p / 5;
            w   = p % 5;
            if (w == 0) begin
                ea = 4'hF;
                es = SB;
            end else begin
                ea = ~(4'b0001 << dig);
                es = d[dig];
            end
            chk({tag, ":an"},      32'(bus.an),         32'(ea));
            chk({tag, ":seg"},     32'(bus.seg),        32'(es));
            chk({tag, ":tick"},    32'(bus.frame_tick), 32'(p == 19));
            chk({tag, ":pending"}, 32'(bus.pending),    32'd0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable    = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = 16'h0000;

        // 1. reset state, then blank scan pattern
        step(2);
        chk("rst:seg",     32'(bus.seg),        32'h7F);
        chk("rst:an",      32'(bus.an),         32'hF);
        chk("rst:pending", 32'(bus.pending),    32'd0);
        chk("rst:tick",    32'(bus.frame_tick), 32'd0);
        rst = 1'b0;
        show_frame("blank0", SB, SB, SB, SB);
        show_frame("blank1", SB, SB, SB, SB);

        // 2. mid-frame load held until boundary
        step(7);
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        step(1);
        chk("l1234:pend_set", 32'(bus.pending), 32'd1);
        wait_tick("l1234");
        chk("l1234:pend_tick", 32'(bus.pending), 32'd1);
        show_frame("f1234", S1, S2, S3, S4);

        // 3. back-to-back loads, then a load on the boundary cycle
        step(3);
        bus.digits_in = 16'h1111;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.digits_in = 16'h5678;
        step(1);
        chk("l5678:pend_set", 32'(bus.pending), 32'd1);
        wait_tick("l5678");
        show_frame("f5678", S5, S6, S7, S8);
        bus.digits_in = 16'h9999;
        bus.load      = 1'b1;
        show_frame("f9999", S9, S9, S9, S9);

        // 4. non-decimal codes blank; async reset mid-dwell
        bus.digits_in = 16'hABCD;
        bus.load      = 1'b1;
        show_frame("fABCD", SB, SB, SB, SB);
        step(3);
        chk("arst:pre_an", 32'(bus.an), 32'hE);
        #2 rst = 1'b1;
        #1;
        chk("arst:seg",     32'(bus.seg),     32'h7F);
        chk("arst:an",      32'(bus.an),      32'hF);
        chk("arst:pending", 32'(bus.pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        show_frame("post_rst", SB, SB, SB, SB);

        // 5. disable, direct load while dark, re-enable
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        show_frame("g1234", S1, S2, S3, S4);
        step(2);
        chk("dis:pre_an", 32'(bus.an), 32'hE);
        bus.enable = 1'b0;
        step(1);
        chk("dis:an",   32'(bus.an),         32'hF);
        chk("dis:seg",  32'(bus.seg),        32'h7F);
        chk("dis:tick", 32'(bus.frame_tick), 32'd0);
        bus.digits_in = 16'h0042;
        bus.load      = 1'b1;
        step(1);
        chk("dis:pending", 32'(bus.pending), 32'd0);
        step(2);
        chk("dis:an_held", 32'(bus.an), 32'hF);
        bus.enable = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        show_frame("f0042", SB, SB, S4, S2);
`else
        show_frame("f0042", S0, S0, S4, S2);
`endif

        // 6. leading zeros
        bus.digits_in = 16'h0050;
        bus.load      = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        show_frame("f0050", SB, SB, S5, S0);
`else
        show_frame("f0050", S0, S0, S5, S0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
